t1_pkencode: RTL and testbench

T1_PKENCODE -- requirements
Module: t1_pkencode

---
 rtl/t1_pkencode_defines_pkg.sv | 29 ++
 rtl/t1_pkencode_if.sv | 25 ++
 rtl/t1_pkencode_buffer.sv | 61 ++++++
 rtl/t1_pkencode.sv | 143 ++++++++++++++
 tb/tb_t1_pkencode.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t1_pkencode_defines_pkg.sv
// t1_pkencode_defines_pkg: shared types and constants for the t1 public-key packer.
//   t1_pack_state_type : packer FSM states
//   t1_beat_t          : one input beat of four 10-bit t1 coefficients (coeff 0 in LSBs)
package t1_pkencode_defines_pkg;

    localparam int unsigned T1_COEFF_W         = 10;
    localparam int unsigned T1_COEFFS_PER_BEAT = 4;
    localparam int unsigned T1_BEATS_PER_POLY  = 64;
    localparam int unsigned T1_WORDS_PER_POLY  = 80;

    localparam int unsigned T1_BEAT_W = T1_COEFF_W * T1_COEFFS_PER_BEAT;
    localparam int unsigned T1_WORD_W = 32;
    localparam int unsigned T1_BUF_W  = T1_WORD_W + T1_BEAT_W;
    localparam int unsigned T1_FILL_W = $clog2(T1_BUF_W + 1);

    typedef enum logic [1:0] {
        T1_PACK_IDLE,
        T1_PACK_RUN,
        T1_PACK_DONE
    } t1_pack_state_type;

    typedef struct packed {
        logic [T1_COEFF_W-1:0] c3;
        logic [T1_COEFF_W-1:0] c2;
        logic [T1_COEFF_W-1:0] c1;
        logic [T1_COEFF_W-1:0] c0;
    } t1_beat_t;

endpackage

// File: rtl/t1_pkencode_if.sv
// t1_pkencode_if: beat-in / word-out handshake bundle of the t1 packer.
//   in_valid/in_data/in_ready    : t1 coefficient beats from power2round
//   out_valid/out_data/out_ready : packed 32-bit pk words
//   master = producer/consumer side, slave = packer side
interface t1_pkencode_if;
    import t1_pkencode_defines_pkg::*;

    logic                 in_valid;
    t1_beat_t             in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [T1_WORD_W-1:0] out_data;
    logic                 out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/t1_pkencode_buffer.sv
// t1_pkencode_buffer: 72-bit LSB-first append/shift buffer with fill count.
//   clk, rst      : clock, async active-high reset
//   clear         : synchronous clear of contents and fill
//   push, din     : append a 40-bit beat at the current fill position
//   pop           : drop the low 32-bit word (applied before a same-cycle push)
//   word_nxt      : low word of the buffer as it will be after this edge
//   fill_nxt      : fill count as it will be after this edge
module t1_pkencode_buffer
    import t1_pkencode_defines_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 push,
    input  logic                 pop,
    input  logic [T1_BEAT_W-1:0] din,
    output logic [T1_WORD_W-1:0] word_nxt,
    output logic [T1_FILL_W-1:0] fill_nxt
);

    logic [T1_BUF_W-1:0]  data_q;
    logic [T1_BUF_W-1:0]  data_d;
    logic [T1_BUF_W-1:0]  shifted;
    logic [T1_FILL_W-1:0] fill_q;
    logic [T1_FILL_W-1:0] fill_d;
    logic [T1_FILL_W-1:0] fill_s;

    // Pop first, then place the new beat just above whatever remains.
    always_comb begin
        shifted = data_q;
        fill_s  = fill_q;
        if (pop) begin
            shifted = data_q >> T1_WORD_W;
            fill_s  = fill_q - T1_FILL_W'(T1_WORD_W);
        end
        data_d = shifted;
        fill_d = fill_s;
        if (push) begin
            data_d = shifted | (T1_BUF_W'(din) << fill_s);
            fill_d = fill_s + T1_FILL_W'(T1_BEAT_W);
        end
        if (clear) begin
            data_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            fill_q <= '0;
        end else begin
            data_q <= data_d;
            fill_q <= fill_d;
        end
    end

    assign word_nxt = data_d[T1_WORD_W-1:0];
    assign fill_nxt = fill_d;

endmodule

// File: rtl/t1_pkencode.sv
// t1_pkencode: packs NUM_POLY t1 polynomials (10-bit coeffs) LSB-first into 32-bit pk words.
//   clk, rst  : clock, async active-high reset
//   zeroize   : synchronous clear of all state and buffered data
//   start     : pulse to begin a run (ignored unless idle)
//   io        : slave side of t1_pkencode_if (beats in, words out)
//   done      : one-cycle pulse after the final word is accepted
//   err       : sticky protocol error, only when T1_PKENCODE_ERR_EN is defined; else tied 0
module t1_pkencode
    import t1_pkencode_defines_pkg::*;
#(
    parameter int unsigned NUM_POLY = 8
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          zeroize,
    input  logic          start,
    t1_pkencode_if.slave  io,
    output logic          done,
    output logic          err
);

    localparam int unsigned BEATS_TOTAL = T1_BEATS_PER_POLY * NUM_POLY;
    localparam int unsigned WORDS_TOTAL = T1_WORDS_PER_POLY * NUM_POLY;
    localparam int unsigned BEAT_CNT_W  = $clog2(BEATS_TOTAL + 1);
    localparam int unsigned WORD_CNT_W  = $clog2(WORDS_TOTAL + 1);

    t1_pack_state_type     state_q;
    t1_pack_state_type     state_d;
    logic [BEAT_CNT_W-1:0] beats_q;
    logic [BEAT_CNT_W-1:0] beats_d;
    logic [WORD_CNT_W-1:0] words_q;
    logic [WORD_CNT_W-1:0] words_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [T1_WORD_W-1:0]  out_data_q;
    logic                  done_q;
    logic                  push;
    logic                  pop;
    logic [T1_WORD_W-1:0]  word_nxt;
    logic [T1_FILL_W-1:0]  fill_nxt;

    t1_pkencode_buffer u_buffer (
        .clk      (clk),
        .rst      (rst),
        .clear    (zeroize),
        .push     (push),
        .pop      (pop),
        .din      (io.in_data),
        .word_nxt (word_nxt),
        .fill_nxt (fill_nxt)
    );

    // Handshakes use only registered ready/valid, so no in->out combinational path.
    always_comb begin
        push    = io.in_valid && in_ready_q;
        pop     = out_valid_q && io.out_ready;
        state_d = state_q;
        beats_d = beats_q;
        words_d = words_q;
        case (state_q)
            T1_PACK_IDLE: begin
                if (start) begin
                    state_d = T1_PACK_RUN;
                    beats_d = BEAT_CNT_W'(BEATS_TOTAL);
                    words_d = WORD_CNT_W'(WORDS_TOTAL);
                end
            end
            T1_PACK_RUN: begin
                if (push) begin
                    beats_d = beats_q - BEAT_CNT_W'(1);
                end
                if (pop) begin
                    words_d = words_q - WORD_CNT_W'(1);
                    if (words_q == WORD_CNT_W'(1)) begin
                        state_d = T1_PACK_DONE;
                    end
                end
            end
            T1_PACK_DONE: state_d = T1_PACK_IDLE;
            default:      state_d = T1_PACK_IDLE;
        endcase
    end

    // State, counters and outputs; outputs are registered from next-cycle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= T1_PACK_IDLE;
            beats_q     <= '0;
            words_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else if (zeroize) begin
            state_q     <= T1_PACK_IDLE;
            beats_q     <= '0;
            words_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beats_q     <= beats_d;
            words_q     <= words_d;
            in_ready_q  <= (state_d == T1_PACK_RUN) && (beats_d != '0) &&
                           (fill_nxt <= T1_FILL_W'(T1_WORD_W));
            out_valid_q <= (state_d == T1_PACK_RUN) && (fill_nxt >= T1_FILL_W'(T1_WORD_W));
            out_data_q  <= word_nxt;
            done_q      <= (state_d == T1_PACK_DONE);
        end
    end

`ifdef T1_PKENCODE_ERR_EN
    logic err_q;
    logic err_evt;

    assign err_evt = (io.in_valid && (state_q != T1_PACK_RUN)) ||
                     (io.in_valid && (state_q == T1_PACK_RUN) && (beats_q == '0)) ||
                     (start && (state_q != T1_PACK_IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (zeroize) begin
            err_q <= 1'b0;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign done         = done_q;

endmodule

// File: tb/tb_t1_pkencode.sv
// tb_t1_pkencode: self-checking bench for t1_pkencode (NUM_POLY=8).
// Reference is a bit-stream model: every accepted coefficient appends 10 bits LSB-first,
// every 32 bits form one expected word. Handshake flags follow the packing rules on that model.
module tb_t1_pkencode;
    import t1_pkencode_defines_pkg::*;

    localparam int NP    = 8;
    localparam int BEATS = 64 * NP;
    localparam int WORDS = 80 * NP;

    logic clk;
    logic rst;
    logic zeroize;
    logic start;
    logic done;
    logic err;

    t1_pkencode_if io ();

    t1_pkencode #(.NUM_POLY(NP)) dut (
        .clk     (clk),
        .rst     (rst),
        .zeroize (zeroize),
        .start   (start),
        .io      (io.slave),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          bits_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_words[$];
    int          phase      = 0;   // 0 idle, 1 running, 2 done cycle
    int          beats_left = 0;
    int          words_left = 0;
    int          beats_acc  = 0;
    int          done_cnt   = 0;
    logic        err_exp    = 1'b0;
    logic        hold_v     = 1'b0;
    logic [31:0] hold_d     = '0;
    logic        acc_in     = 1'b0;

    logic [39:0] beats[BEATS];
    int          rdy_mode = 0;     // 0 always ready, 1 random, 2 held low
    int          rp       = 100;

    task automatic model_clear();
        bits_q.delete();
        exp_q.delete();
        phase      = 0;
        beats_left = 0;
        words_left = 0;
        err_exp    = 1'b0;
        hold_v     = 1'b0;
    endtask

    task automatic model_push(input logic [39:0] d);
        logic [31:0] w;
        for (int i = 0; i < 40; i++) bits_q.push_back(d[i]);
        while (bits_q.size() >= 32) begin
            for (int j = 0; j < 32; j++) w[j] = bits_q.pop_front();
            exp_q.push_back(w);
        end
    endtask

    // Compare process: checks all outputs each cycle, then records handshakes for the next edge.
    always @(negedge clk) begin
        int          fill;
        int          nphase;
        logic [39:0] d;
        acc_in = 1'b0;
        if (rst) begin
            chk("rst_in_ready",  io.in_ready,  0);
            chk("rst_out_valid", io.out_valid, 0);
            chk("rst_out_data",  io.out_data,  0);
            chk("rst_done",      done,         0);
            chk("rst_err",       err,          0);
            model_clear();
        end else begin
            fill = bits_q.size() + 32 * exp_q.size();
            chk("in_ready",  io.in_ready,  (phase == 1 && beats_left > 0 && fill <= 32));
            chk("out_valid", io.out_valid, (phase == 1 && fill >= 32));
            chk("done",      done,         (phase == 2));
            chk("err",       err,          err_exp);
            if (io.out_valid && hold_v) chk("hold_data", io.out_data, hold_d);
            if (io.out_valid) begin
                if (exp_q.size() > 0) chk("out_data", io.out_data, exp_q[0]);
                else                  chk("out_extra", io.out_valid, 0);
            end
            if (done) done_cnt++;
            hold_v = io.out_valid && !io.out_ready;
            hold_d = io.out_data;
            if (zeroize) begin
                model_clear();
            end else begin
`ifdef T1_PKENCODE_ERR_EN
                if ((io.in_valid && (phase != 1 || beats_left == 0)) || (start && phase != 0))
                    err_exp = 1'b1;
`endif
                nphase = phase;
                if (phase == 0 && start) begin
                    nphase     = 1;
                    beats_left = BEATS;
                    words_left = WORDS;
                end else if (phase == 2) begin
                    nphase = 0;
                end
                if (phase == 1 && io.out_valid && io.out_ready && exp_q.size() > 0) begin
                    got_words.push_back(io.out_data);
                    void'(exp_q.pop_front());
                    words_left--;
                    if (words_left == 0) nphase = 2;
                end
                if (phase == 1 && io.in_valid && io.in_ready) begin
                    acc_in = 1'b1;
                    d = io.in_data;
                    model_push(d);
                    beats_left--;
                    beats_acc++;
                end
                phase = nphase;
            end
        end
    end

    // out_ready driver
    initial begin
        io.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       io.out_ready = 1'b1;
                1:       io.out_ready = ($urandom_range(0, 99) < rp);
                default: io.out_ready = 1'b0;
            endcase
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic feed(input int n, input int pv);
        int idx   = 0;
        int guard = 0;
        io.in_valid = 1'b0;
        while (idx < n && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
            if (acc_in) idx++;
            if (idx >= n) begin
                io.in_valid = 1'b0;
            end else if (!(io.in_valid && !acc_in)) begin
                io.in_valid = ($urandom_range(0, 99) < pv);
                io.in_data  = beats[idx];
            end
        end
        io.in_valid = 1'b0;
        chk("feed_progress", idx, n);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic new_run();
        got_words.delete();
        beats_acc = 0;
        pulse_start();
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int i  = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        chk({name, "_done_seen"}, (done_cnt != d0), 1);
        repeat (3) begin @(posedge clk); #1; end
        chk({name, "_done_once"}, done_cnt - d0, 1);
        chk({name, "_words"}, got_words.size(), WORDS);
        chk({name, "_beats"}, beats_acc, BEATS);
        chk({name, "_model_empty"}, exp_q.size() + bits_q.size(), 0);
    endtask

    task automatic rand_beats();
        for (int i = 0; i < BEATS; i++)
            beats[i] = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                        10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
    endtask

    initial begin
        int          nff;
        int          d0;
        logic [31:0] w;
        rst = 1'b1; zeroize = 1'b0; start = 1'b0;
        io.in_valid = 1'b0; io.in_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  io.in_ready,  0);
        chk("reset_out_valid", io.out_valid, 0);
        chk("reset_out_data",  io.out_data,  0);
        chk("reset_done",      done,         0);
        chk("reset_err",       err,          0);
        rst = 1'b0;

        // All-ones coefficients, always ready
        for (int i = 0; i < BEATS; i++) beats[i] = 40'hFF_FFFF_FFFF;
        rdy_mode = 0;
        new_run();
        feed(BEATS, 100);
        wait_done("ones", 3000);
        nff = 0;
        foreach (got_words[i]) if (got_words[i] !== 32'hFFFF_FFFF) nff++;
        chk("ones_non_ffffffff", nff, 0);

        // First beat {1,2,3,4}, random handshakes
        rand_beats();
        beats[0] = {10'd4, 10'd3, 10'd2, 10'd1};
        rdy_mode = 1; rp = 60;
        new_run();
        feed(BEATS, 70);
        wait_done("first", 4000);
        chk("first_word0", got_words[0], 32'h0030_0801);
        w = got_words[1];
        chk("first_word1_lo", w[7:0], 8'h01);

        // Back-pressure: out_ready low for 20 cycles mid-run plus a stray start
        rand_beats();
        rdy_mode = 0;
        new_run();
        fork
            feed(BEATS, 100);
            begin
                repeat (100) @(posedge clk);
                #1 rdy_mode = 2; start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                repeat (19) @(posedge clk);
                #1;
                chk("stall_in_ready", io.in_ready, 0);
                chk("stall_out_valid", io.out_valid, 1);
                rdy_mode = 0;
            end
        join
        wait_done("stall", 3000);

        // Abort by reset after 30 beats, then a fresh run
        rand_beats();
        rdy_mode = 0;
        new_run();
        feed(30, 100);
        @(posedge clk); #1 rst = 1'b1;
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        beats[0] = {10'd8, 10'd7, 10'd6, 10'd5};
        rdy_mode = 1; rp = 70;
        new_run();
        feed(BEATS, 80);
        wait_done("abort", 4000);
        chk("abort_word0", got_words[0], 32'h0070_1805);

        // Random valid/ready full run
        rand_beats();
        rdy_mode = 1; rp = 50;
        new_run();
        feed(BEATS, 60);
        wait_done("random", 6000);

        // in_valid while idle
        @(posedge clk); #1 zeroize = 1'b1;
        @(posedge clk); #1 zeroize = 1'b0;
        chk("zeroize_err", err, 0);
        beats_acc = 0;
        io.in_data  = 40'h12_3456_789A;
        io.in_valid = 1'b1;
        @(posedge clk); #1 io.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`ifdef T1_PKENCODE_ERR_EN
        chk("idle_valid_err", err, 1);
`else
        chk("idle_valid_err", err, 0);
`endif
        chk("idle_valid_beats", beats_acc, 0);
        chk("idle_in_ready", io.in_ready, 0);
        @(posedge clk); #1 zeroize = 1'b1;
        @(posedge clk); #1 zeroize = 1'b0;
        chk("err_cleared", err, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
